// File: rtl/secinput_key_sequencer_pkg.sv
// Shared types and default sizes for the secondary-input key sequencer.
// The state enum is reused by anything that needs to decode the controller state.
package secinput_pkg;

  localparam int NW_DEF      = 1024;
  localparam int N0W_DEF     = 32;
  localparam int TIMEOUT_DEF = 2**20;
  localparam int TW_DEF      = 21;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

endpackage

// File: rtl/secinput_key_sequencer_if.sv
// Host request/status and precompute-unit handshake bundled into one interface.
// The sequencer connects through the slave modport; its environment uses master.
interface secinput_key_sequencer_if
  import secinput_pkg::*;
#(
  parameter int NW  = NW_DEF,
  parameter int N0W = N0W_DEF
);

  logic           start;
  logic           flush;
  logic [NW-1:0]  n;
  logic           busy;
  logic           done;
  logic           error;
  logic           key_valid;
  logic [N0W-1:0] n0p_q;
  logic [NW-1:0]  r_q;
  logic [NW-1:0]  t_q;

  logic           pre_start;
  logic [NW-1:0]  pre_n;
  logic           pre_done;
  logic [N0W-1:0] pre_n0p;
  logic [NW-1:0]  pre_r;
  logic [NW-1:0]  pre_t;

  modport master (
    output start, flush, n, pre_done, pre_n0p, pre_r, pre_t,
    input  busy, done, error, key_valid, n0p_q, r_q, t_q, pre_start, pre_n
  );

  modport slave (
    input  start, flush, n, pre_done, pre_n0p, pre_r, pre_t,
    output busy, done, error, key_valid, n0p_q, r_q, t_q, pre_start, pre_n
  );

endinterface

// File: rtl/secinput_key_sequencer_watchdog.sv
// Saturating cycle counter with clear/enable; expired flags TIMEOUT-1 reached.
// Shared with the exponentiation controller for its own completion watchdog.
module precomp_watchdog #(
  parameter int TIMEOUT = 2**20,
  parameter int TW      = 21
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TW-1:0] cnt;

  assign expired = (cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/secinput_key_sequencer.sv
// Key-load controller for the RSA precompute unit: caches the last modulus,
// launches precompute only on a miss, and holds n0'/r/t stable for exponentiation.
module secinput_key_sequencer
  import secinput_pkg::*;
#(
  parameter int NW      = NW_DEF,
  parameter int N0W     = N0W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TW      = TW_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  secinput_key_sequencer_if.slave  bus
);

  state_t         state, state_nxt;
  logic [NW-1:0]  n_reg;
  logic [NW-1:0]  cached_n;
  logic           cache_hit;
  logic           wd_expired;

  logic           busy_q, done_q, error_q, pre_start_q, key_valid_q;
  logic [N0W-1:0] n0p_q;
  logic [NW-1:0]  r_q, t_q;

  logic           vld_p1;
  logic [N0W-1:0] n0p_p1;
  logic [NW-1:0]  r_p1, t_p1;

  assign cache_hit = key_valid_q && (n_reg == cached_n);

  precomp_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == LAUNCH),
    .en      (state == WAIT),
    .expired (wd_expired)
  );

  // A pre_done seen on the last watchdog cycle holds WAIT one more cycle so
  // the registered completion below can still win over the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CHECK;
      CHECK:   state_nxt = cache_hit ? DONE : LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT: begin
        if (vld_p1)                          state_nxt = DONE;
        else if (wd_expired && !bus.pre_done) state_nxt = ERR;
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p1: precompute completion registered; only levels seen during WAIT count,
  // so a stale pre_done in LAUNCH or IDLE is never captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= bus.pre_done && (state == WAIT);
    end
  end

  always_ff @(posedge clk) begin
    if (bus.pre_done && (state == WAIT)) begin
      n0p_p1 <= bus.pre_n0p;
      r_p1   <= bus.pre_r;
      t_p1   <= bus.pre_t;
    end
  end

  // Control and result registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      pre_start_q <= 1'b0;
      key_valid_q <= 1'b0;
      n_reg       <= '0;
      cached_n    <= '0;
      n0p_q       <= '0;
      r_q         <= '0;
      t_q         <= '0;
    end else begin
      state       <= state_nxt;
      busy_q      <= (state_nxt == CHECK) || (state_nxt == LAUNCH) || (state_nxt == WAIT);
      done_q      <= (state_nxt == DONE);
      error_q     <= (state_nxt == ERR);
      pre_start_q <= (state_nxt == LAUNCH);

      if ((state == IDLE) && bus.start) begin
        n_reg <= bus.n;
      end

      // Flush is evaluated before CHECK, so start+flush always forces a launch.
      if ((state == IDLE) && bus.flush) begin
        key_valid_q <= 1'b0;
      end else if ((state == CHECK) && !cache_hit) begin
        key_valid_q <= 1'b0;
      end else if (state_nxt == DONE) begin
        key_valid_q <= 1'b1;
      end else if (state_nxt == ERR) begin
        key_valid_q <= 1'b0;
      end

      if ((state == WAIT) && vld_p1) begin
        n0p_q    <= n0p_p1;
        r_q      <= r_p1;
        t_q      <= t_p1;
        cached_n <= n_reg;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.key_valid = key_valid_q;
  assign bus.n0p_q     = n0p_q;
  assign bus.r_q       = r_q;
  assign bus.t_q       = t_q;
  assign bus.pre_start = pre_start_q;
  assign bus.pre_n     = n_reg;

endmodule

// File: tb/tb_secinput_key_sequencer.sv
// Bench for secinput_key_sequencer (NW=64, TIMEOUT=16) with a behavioural
// precompute unit; expected results come from a hand-filled vector table.
module tb_secinput_key_sequencer;

  localparam int NW  = 64;
  localparam int N0W = 32;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  secinput_key_sequencer_if #(.NW(NW), .N0W(N0W)) bus ();

  secinput_key_sequencer #(
    .NW      (NW),
    .N0W     (N0W),
    .TIMEOUT (TO),
    .TW      (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [63:0] n;
    int          flush_mode;  // 0 none, 1 flush the cycle before, 2 with start
    int          delay;       // pre_start -> pre_done cycles, -1 never
    int          hold;
    bit          mid;         // extra start during WAIT
    logic [31:0] n0p;
    logic [63:0] r;
    logic [63:0] t;
    int          exp_lat;
    bit          exp_err;
    logic [31:0] e_n0p;
    logic [63:0] e_r;
    logic [63:0] e_t;
    bit          e_kv;
    int          e_launch;
  } vec_t;

  vec_t tbl [12];
  vec_t sb [$];

  int n_cmp  = 0;
  int n_miss = 0;

  int             m_delay = -1;
  int             m_hold  = 1;
  logic [N0W-1:0] m_n0p   = '0;
  logic [NW-1:0]  m_r     = '0;
  logic [NW-1:0]  m_t     = '0;

  int            launches     = 0;
  logic [NW-1:0] seen_pre_n   = '0;
  bit            model_active = 1'b0;
  int            done_cnt     = 0;
  int            err_cnt      = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Precompute unit model: reacts to pre_start, drives pre_done after m_delay
  // cycles for m_hold cycles, bumping the data on every held cycle after the first.
  initial begin
    bus.pre_done = 1'b0;
    bus.pre_n0p  = '0;
    bus.pre_r    = '0;
    bus.pre_t    = '0;
    forever begin
      @(negedge clk);
      if (bus.pre_start) begin
        launches++;
        seen_pre_n = bus.pre_n;
        if (m_delay >= 0) begin
          model_active = 1'b1;
          repeat (m_delay) @(negedge clk);
          bus.pre_done = 1'b1;
          bus.pre_n0p  = m_n0p;
          bus.pre_r    = m_r;
          bus.pre_t    = m_t;
          for (int i = 1; i < m_hold; i++) begin
            @(negedge clk);
            bus.pre_n0p = m_n0p + N0W'(i);
            bus.pre_r   = m_r + NW'(i);
            bus.pre_t   = m_t + NW'(i);
          end
          @(negedge clk);
          bus.pre_done = 1'b0;
          model_active = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus.done)  done_cnt++;
    if (bus.error) err_cnt++;
  end

  task automatic run_vec(input vec_t v);
    int   lat;
    bit   fin;
    int   l0, d0, e0, k;
    vec_t e;
    m_delay = v.delay;
    m_hold  = v.hold;
    m_n0p   = v.n0p;
    m_r     = v.r;
    m_t     = v.t;
    @(negedge clk);
    if (v.flush_mode == 1) begin
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
    end
    l0 = launches;
    d0 = done_cnt;
    e0 = err_cnt;
    bus.start = 1'b1;
    bus.n     = v.n;
    bus.flush = (v.flush_mode == 2);
    sb.push_back(v);
    lat = 0;
    fin = 1'b0;
    while (!fin && lat < 40) begin
      @(negedge clk);
      lat++;
      bus.start = v.mid && (lat == 4);
      bus.flush = 1'b0;
      if (v.mid && lat == 4) bus.n = 64'hFFFF;
      if (lat == 1) chk("busy_after_start", bus.busy, 1);
      if (lat == 2 && v.e_launch != 0) chk("key_valid_dropped_on_miss", bus.key_valid, 0);
      if (bus.done || bus.error) fin = 1'b1;
    end
    e = sb.pop_front();
    chk("finished_in_budget", fin, 1);
    chk("latency", lat, e.exp_lat);
    chk("error_pulse", bus.error, e.exp_err);
    chk("done_pulse", bus.done, !e.exp_err);
    chk("busy_at_end", bus.busy, 0);
    chk("key_valid", bus.key_valid, e.e_kv);
    chk("n0p_q", bus.n0p_q, e.e_n0p);
    chk("r_q", bus.r_q, e.e_r);
    chk("t_q", bus.t_q, e.e_t);
    chk("pre_n_held", bus.pre_n, e.n);
    k = 0;
    while (model_active && k < 60) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk("model_settled", model_active, 0);
    chk("launch_count", launches - l0, e.e_launch);
    if (e.e_launch != 0) chk("pre_n_at_launch", seen_pre_n, e.n);
    chk("single_pulse", (done_cnt - d0) + (err_cnt - e0), 1);
  endtask

  initial begin
    int   d0, e0, k;
    vec_t v;

    tbl[0]  = '{64'hC5, 0, 10, 1, 1'b0, 32'h1234, 64'h55, 64'h77, 14, 1'b0, 32'h1234, 64'h55, 64'h77, 1'b1, 1};
    tbl[1]  = '{64'hC5, 0,  0, 1, 1'b0, 32'h0,    64'h0,  64'h0,   2, 1'b0, 32'h1234, 64'h55, 64'h77, 1'b1, 0};
    tbl[2]  = '{64'hC7, 0,  3, 1, 1'b0, 32'hABCD, 64'h66, 64'h88,  7, 1'b0, 32'hABCD, 64'h66, 64'h88, 1'b1, 1};
    tbl[3]  = '{64'hC7, 1,  5, 1, 1'b0, 32'h4321, 64'h11, 64'h22,  9, 1'b0, 32'h4321, 64'h11, 64'h22, 1'b1, 1};
    tbl[4]  = '{64'hC7, 0,  0, 1, 1'b0, 32'h0,    64'h0,  64'h0,   2, 1'b0, 32'h4321, 64'h11, 64'h22, 1'b1, 0};
    tbl[5]  = '{64'hC7, 2,  2, 1, 1'b0, 32'h5555, 64'h33, 64'h44,  6, 1'b0, 32'h5555, 64'h33, 64'h44, 1'b1, 1};
    tbl[6]  = '{64'hD1, 0, -1, 1, 1'b0, 32'h0,    64'h0,  64'h0,  19, 1'b1, 32'h5555, 64'h33, 64'h44, 1'b0, 1};
    tbl[7]  = '{64'hD1, 0,  4, 1, 1'b1, 32'h7777, 64'h99, 64'hAA,  8, 1'b0, 32'h7777, 64'h99, 64'hAA, 1'b1, 1};
    tbl[8]  = '{64'hD3, 0,  0, 1, 1'b0, 32'h6666, 64'h1,  64'h2,  19, 1'b1, 32'h7777, 64'h99, 64'hAA, 1'b0, 1};
    tbl[9]  = '{64'hE3, 0, 16, 1, 1'b0, 32'h1111, 64'h12, 64'h13, 20, 1'b0, 32'h1111, 64'h12, 64'h13, 1'b1, 1};
    tbl[10] = '{64'hE7, 0, 17, 1, 1'b0, 32'h8888, 64'h3,  64'h4,  19, 1'b1, 32'h1111, 64'h12, 64'h13, 1'b0, 1};
    tbl[11] = '{64'hE5, 0,  6, 5, 1'b0, 32'h2222, 64'h21, 64'h23, 10, 1'b0, 32'h2222, 64'h21, 64'h23, 1'b1, 1};

    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.n     = '0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_key_valid", bus.key_valid, 0);
    chk("rst_pre_start", bus.pre_start, 0);
    chk("rst_n0p_q", bus.n0p_q, 0);
    chk("rst_r_q", bus.r_q, 0);
    chk("rst_t_q", bus.t_q, 0);
    chk("rst_pre_n", bus.pre_n, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // Reset in the middle of WAIT; the precompute model keeps running.
    m_delay = 8;
    m_hold  = 1;
    m_n0p   = 32'h9;
    m_r     = 64'h9;
    m_t     = 64'h9;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = 64'hF1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_in_wait", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_error", bus.error, 0);
    chk("midrst_key_valid", bus.key_valid, 0);
    chk("midrst_pre_start", bus.pre_start, 0);
    chk("midrst_n0p_q", bus.n0p_q, 0);
    chk("midrst_r_q", bus.r_q, 0);
    chk("midrst_pre_n", bus.pre_n, 0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (model_active && k < 60) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk("stale_model_settled", model_active, 0);
    chk("stale_no_done", done_cnt - d0, 0);
    chk("stale_no_error", err_cnt - e0, 0);
    chk("stale_key_valid", bus.key_valid, 0);
    chk("stale_n0p_q", bus.n0p_q, 0);
    chk("stale_busy", bus.busy, 0);

    v = '{64'hF1, 0, 2, 1, 1'b0, 32'h3333, 64'h31, 64'h32, 6, 1'b0, 32'h3333, 64'h31, 64'h32, 1'b1, 1};
    run_vec(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/secinput_key_sequencer.md
Name: secinput_key_sequencer

Overview:
- Controller in front of the secondary-input precompute datapath (computes r, t, n0' from modulus n) in the RSA decryption core.
- Accepts a new-key request, launches the precompute unit only when the modulus differs from the cached one, and watches for a timeout.
- Latches and holds n0p/r/t stable for the Montgomery exponentiation stage, and reports ready/done/error.

Parameters:
- NW, 1024, modulus and r/t width in bits.
- N0W, 32, n0' width in bits.
- TIMEOUT, 2**20, max cycles to wait for pre_done before error; must be >= 2.
- TW, 21, timeout counter width; must satisfy 2**TW > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to load key n; ignored unless state is IDLE.
- flush  in  1  invalidates the cache; takes effect in IDLE only.
- n  in  NW  modulus, sampled on the accepted start cycle.
- busy  out  1  high from the cycle after an accepted start until done or error pulses.
- done  out  1  one-cycle pulse when outputs are valid for the requested n.
- error  out  1  one-cycle pulse on timeout.
- key_valid  out  1  n0p_q/r_q/t_q match cached_n.
- n0p_q  out  N0W  latched n0'.
- r_q  out  NW  latched r.
- t_q  out  NW  latched t.
- pre_start  out  1  one-cycle start pulse to the precompute unit.
- pre_n  out  NW  modulus to the precompute unit; driven from the internal n register, stable while busy.
- pre_done  in  1  completion from the precompute unit; a pulse of 1 or more cycles.
- pre_n0p  in  N0W  precompute n0' result.
- pre_r  in  NW  precompute r result.
- pre_t  in  NW  precompute t result.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy/done/error/pre_start/key_valid=0; n0p_q/r_q/t_q/cached_n/n_reg=0; timeout counter=0.
- IDLE:
  - flush=1 clears key_valid next cycle.
  - start=1 latches n into n_reg, busy=1, then go to CHECK.
  - start and flush in the same cycle: flush applies first, so the start always launches the precompute unit.
- CHECK (1 cycle):
  - If key_valid && n_reg==cached_n, go to DONE. Cache-hit latency is start to done = 2 cycles.
  - Otherwise clear key_valid and go to LAUNCH.
- LAUNCH (1 cycle): pre_start=1, counter cleared, go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - pre_done=1: capture pre_n0p/pre_r/pre_t into n0p_q/r_q/t_q, set cached_n=n_reg, go to DONE.
  - Counter reaches TIMEOUT-1 without pre_done: go to ERR.
  - pre_done on the timeout cycle: pre_done wins.
  - pre_done asserted in the LAUNCH cycle: ignored (stale level from the previous run).
- DONE (1 cycle): done=1, key_valid=1, busy=0, go to IDLE.
- ERR (1 cycle): error=1, key_valid=0, busy=0, go to IDLE. The q outputs keep their old values but are not valid.
- Miss latency: start to done = 4 + (cycles from pre_start to pre_done).
- start outside IDLE is dropped, with no queueing. flush outside IDLE is dropped.
- n changes while busy have no effect; only n_reg is used.
- pre_done held high across multiple cycles gives exactly one capture.
- Reset mid-operation returns to IDLE with no pulse. The precompute unit is not aborted; its later pre_done arrives in IDLE and is ignored.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package secinput_pkg holds:
  - state enum {IDLE, CHECK, LAUNCH, WAIT, DONE, ERR}, 3-bit encoding;
  - default NW/N0W/TIMEOUT constants.
- Sub-module precomp_watchdog (counter with clear/enable/expired, parameter TIMEOUT). It is natural and reusable by the exponentiation controller.
- The precompute unit itself is instantiated by the parent, not inside this block.

Test Plan:
- Miss path: after reset, start with n=0xC5 (NW=64 build); model asserts pre_done 10 cycles after pre_start with n0p=0x1234, r=0x55, t=0x77 -> exactly one pre_start, done at start+14, q outputs 0x1234/0x55/0x77, key_valid=1.
- Cache hit: repeat start with n=0xC5 -> no pre_start, done at start+2, q outputs unchanged.
- Different key: start with n=0xC7 -> key_valid drops in CHECK, pre_start issued, new values captured. Then flush in IDLE, then start n=0xC7 -> pre_start issued again.
- Timeout: TIMEOUT=16, model never asserts pre_done -> error pulse 1 cycle, key_valid=0, busy low. A next start retries successfully.
- Boundary cases:
  - pre_done on the final timeout cycle -> done, not error.
  - pre_done held 5 cycles -> single capture.
  - start during WAIT -> ignored.
- Reset mid-WAIT: deassert rst_n at WAIT cycle 3 -> all outputs 0 immediately. A stale pre_done afterwards changes nothing. A fresh start works.
